stroke_interp: RTL and testbench

Line interpolator between `map_cam` and `write_buffer`. Once per frame it samples the remapped camera position. It then emits every pixel on the straight line from the previous pen position to the new one, using Bresenham stepping. Points leave on a valid/ready stream, so fast pen movements draw continuous strokes instead of isolated dots.

---
 rtl/graf_pkg.sv | 18 +
 rtl/abs_delta.sv | 14 +
 rtl/stroke_interp.sv | 163 ++++++++++++++++
 tb/tb_stroke_interp.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/graf_pkg.sv
// Shared graphics-path constants and types used by the stroke interpolator and
// the write buffer.
package graf_pkg;

  localparam int unsigned CW    = 10;
  localparam int unsigned MAX_X = 639;
  localparam int unsigned MAX_Y = 479;

  typedef logic [CW-1:0] coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StDraw,
    StDone
  } stroke_state_t;

endpackage

// File: rtl/abs_delta.sv
// Combinational |a - b| with the direction needed to step from b towards a.
module abs_delta #(
  parameter int unsigned W = 10
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] mag_o,
  output logic         neg_o
);

  assign neg_o = (a_i < b_i);
  assign mag_o = neg_o ? (b_i - a_i) : (a_i - b_i);

endmodule

// File: rtl/stroke_interp.sv
// Per-frame pen sampler that streams every Bresenham pixel between the previous
// and the new pen position over a valid/ready interface.
module stroke_interp
  import graf_pkg::*;
#(
  parameter int unsigned CW         = graf_pkg::CW,
  parameter int unsigned MAX_X      = graf_pkg::MAX_X,
  parameter int unsigned MAX_Y      = graf_pkg::MAX_Y,
  parameter int unsigned JUMP_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] cam_x,
  input  logic [CW-1:0] cam_y,
  input  logic          cam_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DW = CW + 2;

  stroke_state_t state_q;

  logic [CW-1:0] x_q, y_q, end_x_q, end_y_q;
  logic [CW-1:0] cur_x_q, cur_y_q, prev_x_q, prev_y_q;
  logic          cur_valid_q, have_prev_q;
  logic          sx_neg_q, sy_neg_q;
  logic signed [DW-1:0] dx_q, dy_q, err_q;
  logic          pix_valid_q, busy_q, done_q;

  logic [CW-1:0] clamp_x, clamp_y;
  assign clamp_x = (cam_x > CW'(MAX_X)) ? CW'(MAX_X) : cam_x;
  assign clamp_y = (cam_y > CW'(MAX_Y)) ? CW'(MAX_Y) : cam_y;

  logic [CW-1:0] mag_x, mag_y;
  logic          neg_x, neg_y;

  abs_delta #(.W(CW)) u_delta_x (
    .a_i   (cur_x_q),
    .b_i   (prev_x_q),
    .mag_o (mag_x),
    .neg_o (neg_x)
  );

  abs_delta #(.W(CW)) u_delta_y (
    .a_i   (cur_y_q),
    .b_i   (prev_y_q),
    .mag_o (mag_y),
    .neg_o (neg_y)
  );

  // A large move means the pen was lifted: draw only the new point.
  logic jump, line_mode;
  assign jump      = (32'(mag_x) > JUMP_LIMIT) || (32'(mag_y) > JUMP_LIMIT);
  assign line_mode = have_prev_q && !jump;

  logic signed [DW-1:0] setup_dx, setup_dy;
  assign setup_dx = line_mode ? DW'(mag_x) : '0;
  assign setup_dy = line_mode ? -DW'(mag_y) : '0;

  logic signed [DW:0]   e2, dx_e, dy_e;
  logic                 step_x, step_y, at_end;
  logic signed [DW-1:0] err_nx;
  logic [CW-1:0]        x_nx, y_nx;

  assign e2     = {err_q, 1'b0};
  assign dx_e   = {dx_q[DW-1], dx_q};
  assign dy_e   = {dy_q[DW-1], dy_q};
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign err_nx = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
  assign x_nx   = step_x ? (sx_neg_q ? x_q - 1'b1 : x_q + 1'b1) : x_q;
  assign y_nx   = step_y ? (sy_neg_q ? y_q - 1'b1 : y_q + 1'b1) : y_q;
  assign at_end = (x_q == end_x_q) && (y_q == end_y_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      end_x_q     <= '0;
      end_y_q     <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      prev_x_q    <= '0;
      prev_y_q    <= '0;
      cur_valid_q <= 1'b0;
      have_prev_q <= 1'b0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cur_x_q     <= clamp_x;
            cur_y_q     <= clamp_y;
            cur_valid_q <= cam_valid;
            busy_q      <= 1'b1;
            state_q     <= StSetup;
          end
        end
        StSetup: begin
          if (!cur_valid_q) begin
            have_prev_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            x_q         <= line_mode ? prev_x_q : cur_x_q;
            y_q         <= line_mode ? prev_y_q : cur_y_q;
            end_x_q     <= cur_x_q;
            end_y_q     <= cur_y_q;
            sx_neg_q    <= neg_x;
            sy_neg_q    <= neg_y;
            dx_q        <= setup_dx;
            dy_q        <= setup_dy;
            err_q       <= setup_dx + setup_dy;
            pix_valid_q <= 1'b1;
            state_q     <= StDraw;
          end
        end
        StDraw: begin
          if (pix_ready) begin
            if (at_end) begin
              pix_valid_q <= 1'b0;
              prev_x_q    <= end_x_q;
              prev_y_q    <= end_y_q;
              have_prev_q <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              x_q   <= x_nx;
              y_q   <= y_nx;
              err_q <= err_nx;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pix_x     = x_q;
  assign pix_y     = y_q;
  assign pix_valid = pix_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_stroke_interp.sv
// Self-checking bench for stroke_interp: directed cases from the test plan plus
// randomized pen moves against a software line-drawing model.
module tb_stroke_interp;

  localparam int CW    = 10;
  localparam int MAX_X = 639;
  localparam int MAX_Y = 479;
  localparam int JL    = 64;

  logic          clk = 1'b0;
  logic          reset, start, cam_valid, pix_ready;
  logic [CW-1:0] cam_x, cam_y, pix_x, pix_y;
  logic          pix_valid, busy, done;

  always #5 clk = ~clk;

  stroke_interp #(
    .CW(CW), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .JUMP_LIMIT(JL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cam_x     (cam_x),
    .cam_y     (cam_y),
    .cam_valid (cam_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {int x; int y;} pt_t;

  pt_t exp_q[$];
  pt_t got_log[$];
  int  pres_hist[$];
  int  n_cmp = 0, n_err = 0;
  int  cyc = 0;
  int  empty_done_cyc = -10;
  int  first_valid_cyc = -1;
  int  done_cyc = -1;
  int  pres_cnt = 0;
  bit  final_hs_prev = 0, last_valid = 0, last_ready = 0, rst_prev = 0;

  // Model state: previous pen position as seen by the pen-lift rules.
  bit  m_have_prev = 0;
  int  m_px = 0, m_py = 0;

  int  ready_mode = 0;
  int  stall_left = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Compute the expected point list for one frame and advance the model.
  task automatic model_frame(input int x, input int y, input bit v, output int npts);
    int cx, cy, x0, y0, dx, dy, sx, sy, err, e2;
    cx = (x > MAX_X) ? MAX_X : x;
    cy = (y > MAX_Y) ? MAX_Y : y;
    npts = 0;
    if (!v) begin
      m_have_prev = 0;
      return;
    end
    if (!m_have_prev || iabs(cx - m_px) > JL || iabs(cy - m_py) > JL) begin
      x0 = cx;
      y0 = cy;
    end else begin
      x0 = m_px;
      y0 = m_py;
    end
    dx  = iabs(cx - x0);
    dy  = -iabs(cy - y0);
    sx  = (cx >= x0) ? 1 : -1;
    sy  = (cy >= y0) ? 1 : -1;
    err = dx + dy;
    forever begin
      exp_q.push_back('{x0, y0});
      npts++;
      if (x0 == cx && y0 == cy) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x0 += sx; end
      if (e2 <= dx) begin err += dx; y0 += sy; end
    end
    m_have_prev = 1;
    m_px = cx;
    m_py = cy;
  endtask

  // Compare process: every output checked against the model on every cycle.
  always @(negedge clk) begin
    if (rst_prev) begin
      check("pix_valid after reset", int'(pix_valid), 0);
      check("busy after reset", int'(busy), 0);
      check("done after reset", int'(done), 0);
    end else begin
      check("done", int'(done), int'(final_hs_prev || (cyc == empty_done_cyc)));
      if (done) done_cyc = cyc;
      if (pix_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        check("busy while valid", int'(busy), 1);
        if (exp_q.size() == 0) begin
          check("unexpected point", 1, 0);
        end else begin
          check("pix_x", int'(pix_x), exp_q[0].x);
          check("pix_y", int'(pix_y), exp_q[0].y);
        end
        pres_cnt++;
      end
      if (last_valid && !last_ready) check("valid held under stall", int'(pix_valid), 1);
      final_hs_prev = 0;
      if (pix_valid && pix_ready && exp_q.size() > 0) begin
        got_log.push_back('{int'(pix_x), int'(pix_y)});
        pres_hist.push_back(pres_cnt);
        pres_cnt = 0;
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) final_hs_prev = 1;
      end
    end
    if (reset) begin
      exp_q.delete();
      final_hs_prev  = 0;
      pres_cnt       = 0;
      empty_done_cyc = -10;
    end
    last_valid = pix_valid;
    last_ready = pix_ready;
    rst_prev   = reset;
    cyc++;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (got_log.size() == 1 && stall_left > 0) begin
          pix_ready = 1'b0;
          stall_left--;
        end else begin
          pix_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic launch(input int x, input int y, input bit v, output int npts, output int s);
    model_frame(x, y, v, npts);
    got_log.delete();
    pres_hist.delete();
    first_valid_cyc = -1;
    done_cyc = -1;
    @(posedge clk);
    #1;
    cam_x     = CW'(x);
    cam_y     = CW'(y);
    cam_valid = v;
    start     = 1'b1;
    s         = cyc;
    if (npts == 0) empty_done_cyc = s + 2;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cam_x     = CW'($urandom);
    cam_y     = CW'($urandom);
    cam_valid = $urandom_range(0, 1) != 0;
    @(negedge clk);
    check("busy in setup", int'(busy), 1);
  endtask

  task automatic frame(input int x, input int y, input bit v);
    int npts, s, k;
    launch(x, y, v, npts, s);
    for (k = 0; k < 3000 && !done; k++) @(negedge clk);
    if (!done) check("done timeout", 0, 1);
    @(negedge clk);
    check("busy after done", int'(busy), 0);
    check("points left over", exp_q.size(), 0);
    check("point count", got_log.size(), npts);
    if (npts == 0) check("empty frame done latency", done_cyc - s, 2);
    else check("first point latency", first_valid_cyc - s, 2);
  endtask

  task automatic check_pts(input string name, input pt_t ref_pts[$]);
    check({name, " count"}, got_log.size(), ref_pts.size());
    for (int i = 0; i < ref_pts.size() && i < got_log.size(); i++) begin
      check({name, " x"}, got_log[i].x, ref_pts[i].x);
      check({name, " y"}, got_log[i].y, ref_pts[i].y);
    end
  endtask

  initial begin
    pt_t ref_pts[$];
    int  npts, s, nx, ny;
    reset = 1'b1; start = 1'b0; cam_valid = 1'b0; cam_x = '0; cam_y = '0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pix_x", int'(pix_x), 0);
    check("reset pix_y", int'(pix_y), 0);
    check("reset pix_valid", int'(pix_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    @(posedge clk); #1 reset = 1'b0;

    frame(10, 20, 1);
    ref_pts = '{'{10, 20}};
    check_pts("first point", ref_pts);

    frame(14, 20, 1);
    ref_pts = '{'{10, 20}, '{11, 20}, '{12, 20}, '{13, 20}, '{14, 20}};
    check_pts("horizontal", ref_pts);
    foreach (pres_hist[i]) check("back-to-back", pres_hist[i], 1);

    frame(0, 0, 1);
    frame(2, 5, 1);
    ref_pts = '{'{0, 0}, '{0, 1}, '{1, 2}, '{1, 3}, '{2, 4}, '{2, 5}};
    check_pts("steep", ref_pts);

    frame(0, 0, 1);
    ready_mode = 2;
    stall_left = 3;
    frame(2, 5, 1);
    check_pts("steep stalled", ref_pts);
    if (pres_hist.size() > 1) check("stalled hold cycles", pres_hist[1], 4);
    else check("stalled hold cycles", pres_hist.size(), 2);
    ready_mode = 0;

    frame(0, 0, 1);
    frame(300, 0, 1);
    ref_pts = '{'{300, 0}};
    check_pts("jump", ref_pts);
    frame(700, 0, 1);
    ref_pts = '{'{639, 0}};
    check_pts("clamp x", ref_pts);
    frame(639, 900, 1);
    ref_pts = '{'{639, 479}};
    check_pts("clamp y", ref_pts);

    frame(100, 100, 0);
    check("no points when invalid", got_log.size(), 0);
    frame(5, 5, 1);
    ref_pts = '{'{5, 5}};
    check_pts("after invalid", ref_pts);

    frame(0, 0, 1);
    launch(49, 20, 1, npts, s);
    check("long line length", npts, 50);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_have_prev = 0;
    @(negedge clk);
    check("valid low after reset", int'(pix_valid), 0);
    frame(30, 30, 1);
    ref_pts = '{'{30, 30}};
    check_pts("after reset", ref_pts);

    // start coincident with reset must be ignored
    @(posedge clk); #1 reset = 1'b1; start = 1'b1; cam_valid = 1'b1;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start under reset busy", int'(busy), 0);
    m_have_prev = 0;

    ready_mode = 1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        nx = $urandom_range(0, 1023);
        ny = $urandom_range(0, 1023);
      end else begin
        nx = m_px + $urandom_range(0, 180) - 90;
        ny = m_py + $urandom_range(0, 180) - 90;
        if (nx < 0) nx = 0;
        if (ny < 0) ny = 0;
        if (nx > 1023) nx = 1023;
        if (ny > 1023) ny = 1023;
      end
      frame(nx, ny, $urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
